// File: rtl/regfile_sb_pkg.sv
// Shared CPU register-file constants: default geometry and the hardwired zero register.
// No logic of its own; imported by the interface, the top and the scoreboard.
// Provides idx_live(): true when an index names a real, writable register.
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRP  = 2;
    localparam int REG_ZERO = 0;

    // Index 0 is hardwired and indices past the array do not exist; neither
    // may be written, reserved or read back as anything but zero / not busy.
    function automatic bit idx_live(input int idx, input int nreg);
        return (idx != REG_ZERO) && (idx < nreg);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of writeback, read, reservation and scoreboard signals of the register file.
// master: the pipeline side (drives writebacks, read indices, reservations, flush).
// slave: the register file (returns read data, per-port busy and the busy vector).
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRP  = DEF_NRP
);
    localparam int AW = $clog2(NREG);

    logic                 wb0_en;
    logic [AW-1:0]        wb0_idx;
    logic [XLEN-1:0]      wb0_data;
    logic                 wb1_en;
    logic [AW-1:0]        wb1_idx;
    logic [XLEN-1:0]      wb1_data;
    logic [NRP*AW-1:0]    rs_idx;
    logic [NRP*XLEN-1:0]  rs_data;
    logic [NRP-1:0]       rs_busy;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_idx;
    logic                 flush;
    logic [NREG-1:0]      busy_vec;

    modport master (
        output wb0_en, wb0_idx, wb0_data, wb1_en, wb1_idx, wb1_data,
        output rs_idx, rsv_en, rsv_idx, flush,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  wb0_en, wb0_idx, wb0_data, wb1_en, wb1_idx, wb1_data,
        input  rs_idx, rsv_en, rsv_idx, flush,
        output rs_data, rs_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set, writebacks clear, flush clears all.
// Latency: busy_vec is registered (one edge); rs_busy is combinational from rs_idx_i.
// Backpressure: none; every reservation/writeback is accepted in the cycle presented.
// Ports: clk/rst_n; wb{0,1}_en_i/idx_i writeback targets; rsv_en_i/rsv_idx_i issue
// reservation; flush_i clears; rs_idx_i read indices; busy_vec_o, rs_busy_o status.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int NRP    = DEF_NRP,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb0_en_i,
    input  logic [AW-1:0]     wb0_idx_i,
    input  logic              wb1_en_i,
    input  logic [AW-1:0]     wb1_idx_i,
    input  logic              rsv_en_i,
    input  logic [AW-1:0]     rsv_idx_i,
    input  logic              flush_i,
    input  logic [NRP*AW-1:0] rs_idx_i,
    output logic [NREG-1:0]   busy_vec_o,
    output logic [NRP-1:0]    rs_busy_o
);

    // Register 0 is never busy, so it has no flop.
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] busy_vec;

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (rsv_en_i && (rsv_idx_i == AW'(i))) begin
                // Reservation beats a coincident writeback: the new producer
                // has not delivered yet even though the old one just did.
                busy_d[i] = 1'b1;
            end else if ((wb0_en_i && (wb0_idx_i == AW'(i))) ||
                         (wb1_en_i && (wb1_idx_i == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec   = {busy_q, 1'b0};
    assign busy_vec_o = busy_vec;

    always_comb begin
        logic [AW-1:0] idx;
        logic          wb_hit;
        idx       = '0;
        wb_hit    = 1'b0;
        rs_busy_o = '0;
        for (int k = 0; k < NRP; k++) begin
            idx    = rs_idx_i[k*AW +: AW];
            wb_hit = (wb0_en_i && (wb0_idx_i == idx)) ||
                     (wb1_en_i && (wb1_idx_i == idx));
            if (idx_live(int'(idx), NREG)) begin
                // With forwarding the operand arrives this cycle, so it is ready.
                rs_busy_o[k] = busy_vec[idx] && !((BYPASS != 0) && wb_hit);
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with optional writeback forwarding and busy scoreboard.
// Latency: zero-cycle combinational reads; writes and busy updates land at the rising edge.
// Backpressure: none; both writeback ports and the reservation port always accept.
// Ports: clk (sole clock), rst_n (async active-low), rf (slave modport of regfile_sb_if:
// two writeback ports, NRP read ports with busy flags, reserve/flush, busy vector).
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int NRP    = DEF_NRP,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave rf
);

    localparam int AW = $clog2(NREG);

    // Entry 0 only ever holds its reset value; reads of it are masked anyway.
    logic [XLEN-1:0]     regs_q [NREG];
    logic [NRP*XLEN-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                // wb1 is the younger instruction, so it wins a same-index collision.
                if (rf.wb1_en && (rf.wb1_idx == AW'(i))) begin
                    regs_q[i] <= rf.wb1_data;
                end else if (rf.wb0_en && (rf.wb0_idx == AW'(i))) begin
                    regs_q[i] <= rf.wb0_data;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] val;
        idx     = '0;
        val     = '0;
        rd_data = '0;
        for (int k = 0; k < NRP; k++) begin
            idx = rf.rs_idx[k*AW +: AW];
            val = '0;
            // Gated by rst_n so a forwarded writeback cannot leak out during reset.
            if (rst_n && idx_live(int'(idx), NREG)) begin
                if ((BYPASS != 0) && rf.wb1_en && (rf.wb1_idx == idx)) begin
                    val = rf.wb1_data;
                end else if ((BYPASS != 0) && rf.wb0_en && (rf.wb0_idx == idx)) begin
                    val = rf.wb0_data;
                end else begin
                    val = regs_q[idx];
                end
            end
            rd_data[k*XLEN +: XLEN] = val;
        end
    end

    assign rf.rs_data = rd_data;

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRP    (NRP),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb0_en_i   (rf.wb0_en),
        .wb0_idx_i  (rf.wb0_idx),
        .wb1_en_i   (rf.wb1_en),
        .wb1_idx_i  (rf.wb1_idx),
        .rsv_en_i   (rf.rsv_en),
        .rsv_idx_i  (rf.rsv_idx),
        .flush_i    (rf.flush),
        .rs_idx_i   (rf.rs_idx),
        .busy_vec_o (rf.busy_vec),
        .rs_busy_o  (rf.rs_busy)
    );

endmodule
